// File: rtl/datapath_pkg.sv
// datapath_pkg: encodings and helpers shared by the RV32I single-cycle datapath.
//   - imm_src_e    : immediate formats selected by ImmSrc
//   - result_src_e : write-back sources selected by ResultSrc
//   - alu_op_e     : ALU operations selected by ALUControl
//   - imm_extend() : sign-extended immediate builder
package datapath_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  // Only instr[31:7] carries immediate bits; the opcode field is never needed.
  function automatic logic [XLEN-1:0] imm_extend(input logic [31:7] ins,
                                                 input imm_src_e    src);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (src)
      IMM_I: imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B: imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J: imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/datapath_regfile.sv
// regfile: 32 x 32-bit register file.
//   i_clk, i_rst_n     : clock, asynchronous active-low clear of all entries
//   i_a1, i_a2         : asynchronous read addresses -> o_rd1, o_rd2
//   i_a3, i_we3, i_wd3 : synchronous write port (writes to x0 are dropped)
// Entry 0 is forced to read zero regardless of storage contents.
module regfile
  import datapath_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [4:0]      i_a1,
  input  logic [4:0]      i_a2,
  input  logic [4:0]      i_a3,
  input  logic            i_we3,
  input  logic [XLEN-1:0] i_wd3,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] rf [0:31];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (i_we3 && (i_a3 != 5'd0)) begin
      rf[i_a3] <= i_wd3;
    end
  end

  assign o_rd1 = (i_a1 == 5'd0) ? '0 : rf[i_a1];
  assign o_rd2 = (i_a2 == 5'd0) ? '0 : rf[i_a2];

endmodule

// File: rtl/datapath.sv
// datapath: single-cycle RV32I datapath (PC, register file, immediate
// extender, ALU, write-back and next-PC muxes). One instruction retires
// per rising clk edge.
//   clk, rst_n   : clock, asynchronous active-low reset (PC and registers -> 0)
//   instr        : instruction at PC
//   RegWrite     : write Result into rd at the edge
//   ImmSrc       : immediate format (I/S/B/J)
//   ALUSrcB      : ALU B operand, 0 RD2 / 1 ImmExt
//   ResultSrc    : write-back select (ALU / ReadData / PC+4 / ImmExt)
//   PCSrc        : next PC, 0 PC+4 / 1 PC+ImmExt
//   ReadData     : data-memory read data
//   ALUControl   : ALU operation
//   PC           : current program counter
//   Zero         : ALUResult == 0
//   ALUResult    : ALU output / data-memory address
//   WriteData    : RD2, store data
module datapath
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        RegWrite,
  input  logic [1:0]  ImmSrc,
  input  logic        ALUSrcB,
  input  logic [1:0]  ResultSrc,
  input  logic        PCSrc,
  input  logic [31:0] ReadData,
  input  logic [2:0]  ALUControl,
  output logic [31:0] PC,
  output logic        Zero,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_target;
  logic [XLEN-1:0] w_pc_next;
  logic            w_unused_opcode;

  // Opcode bits are decoded outside this block.
  assign w_unused_opcode = ^instr[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  regfile rf (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_a1    (instr[19:15]),
    .i_a2    (instr[24:20]),
    .i_a3    (instr[11:7]),
    .i_we3   (RegWrite),
    .i_wd3   (w_result),
    .o_rd1   (w_rd1),
    .o_rd2   (w_rd2)
  );

  assign w_imm_ext = imm_extend(instr[31:7], imm_src_e'(ImmSrc));
  assign w_src_b   = ALUSrcB ? w_imm_ext : w_rd2;

  always_comb begin
    w_alu_result = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD: w_alu_result = w_rd1 + w_src_b;
      ALU_SUB: w_alu_result = w_rd1 - w_src_b;
      ALU_AND: w_alu_result = w_rd1 & w_src_b;
      ALU_OR:  w_alu_result = w_rd1 | w_src_b;
      ALU_XOR: w_alu_result = w_rd1 ^ w_src_b;
      ALU_SLT: w_alu_result = {31'b0, ($signed(w_rd1) < $signed(w_src_b))};
      default: w_alu_result = '0;
    endcase
  end

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_pc_target = r_pc + w_imm_ext;
  assign w_pc_next   = PCSrc ? w_pc_target : w_pc_plus4;

  always_comb begin
    w_result = w_alu_result;
    case (result_src_e'(ResultSrc))
      RES_ALU: w_result = w_alu_result;
      RES_MEM: w_result = ReadData;
      RES_PC4: w_result = w_pc_plus4;
      RES_IMM: w_result = w_imm_ext;
      default: w_result = w_alu_result;
    endcase
  end

  assign PC        = r_pc;
  assign ALUResult = w_alu_result;
  assign Zero      = (w_alu_result == '0);
  assign WriteData = w_rd2;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed program for the single-cycle datapath. Stimulus
// pushes hand-computed expectations into a queue; a monitor pops and
// compares them at the falling edge (or on demand during reset pulses).
module tb_datapath;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrcB;
  logic [1:0]  ResultSrc;
  logic        PCSrc;
  logic [31:0] ReadData;
  logic [2:0]  ALUControl;
  logic [31:0] PC;
  logic        Zero;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;

  datapath dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .PCSrc      (PCSrc),
    .ReadData   (ReadData),
    .ALUControl (ALUControl),
    .PC         (PC),
    .Zero       (Zero),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {S_PC, S_ALU, S_ZERO, S_WD, S_RF, S_RFALL} sel_e;
  typedef struct {
    sel_e        sel;
    int          idx;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic push_chk(input sel_e s, input int idx, input logic [31:0] v,
                          input string nm);
    chk_t c;
    c.sel = s;
    c.idx = idx;
    c.exp = v;
    c.nm  = nm;
    q.push_back(c);
  endtask

  // Monitor
  chk_t        m_c;
  logic [31:0] m_act;
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        m_c   = q.pop_front();
        m_act = '0;
        case (m_c.sel)
          S_PC:    m_act = PC;
          S_ALU:   m_act = ALUResult;
          S_ZERO:  m_act = {31'b0, Zero};
          S_WD:    m_act = WriteData;
          S_RF:    m_act = dut.rf.rf[m_c.idx];
          S_RFALL: for (int i = 0; i < 32; i++) m_act = m_act | dut.rf.rf[i];
          default: m_act = 'x;
        endcase
        n_checks++;
        if (m_act !== m_c.exp) begin
          n_errors++;
          $display("FAIL %s: actual=%h required=%h (t=%0t)", m_c.nm, m_act, m_c.exp, $time);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic rw, input logic [1:0] imm,
                       input logic asb, input logic [1:0] rs, input logic pcs,
                       input logic [2:0] alu, input logic [31:0] rdata);
    instr      = ins;
    RegWrite   = rw;
    ImmSrc     = imm;
    ALUSrcB    = asb;
    ResultSrc  = rs;
    PCSrc      = pcs;
    ALUControl = alu;
    ReadData   = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  ops  [6];
  logic [31:0] opr  [6];
  string       opn  [6];

  initial begin
    ops = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b111, 3'b001};
    opr = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'hFFFF_FFFE};
    opn = '{"and", "or", "xor", "op110", "op111", "sub_wrap"};

    rst_n = 1'b0;
    drive(32'h0000_0013, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
    tick();
    #1;
    push_chk(S_PC, 0, 32'h0, "reset_pc");
    push_chk(S_RFALL, 0, 32'h0, "reset_rf");
    push_chk(S_WD, 0, 32'h0, "reset_wd");
    -> chk_ev;
    #1 rst_n = 1'b1;

    // PC 0: addi x5,x0,3
    drive(32'h0030_0293, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_ALU, 0, 32'd3, "addi1_alu");
    push_chk(S_PC, 0, 32'h0, "addi1_pc");
    tick();
    // PC 4: addi x5,x5,3
    drive(32'h0032_8293, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_PC, 0, 32'h4, "addi2_pc");
    push_chk(S_RF, 5, 32'd3, "x5_after_addi1");
    push_chk(S_ALU, 0, 32'd6, "addi2_alu");
    push_chk(S_RF, 0, 32'h0, "x0_zero_a");
    tick();
    // PC 8: beq x5,x5,-8 (sub, branch taken)
    drive(32'hFE52_8CE3, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 3'b001, 32'h0);
    push_chk(S_PC, 0, 32'h8, "beq_pc");
    push_chk(S_RF, 5, 32'd6, "x5_after_addi2");
    push_chk(S_ALU, 0, 32'h0, "sub_eq_alu");
    push_chk(S_ZERO, 0, 32'h1, "sub_eq_zero");
    push_chk(S_WD, 0, 32'd6, "beq_wd_x5");
    tick();
    // PC 0: addi x0,x0,7
    drive(32'h0070_0013, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_PC, 0, 32'h0, "branch_target");
    push_chk(S_ALU, 0, 32'd7, "addi_x0_alu");
    push_chk(S_RF, 5, 32'd6, "x5_hold");
    tick();
    // PC 4: jal x1,+2048
    drive(32'h0010_00EF, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 3'b000, 32'h0);
    push_chk(S_PC, 0, 32'h4, "jal_pc");
    push_chk(S_RF, 0, 32'h0, "x0_write_ignored");
    tick();
    // PC 0x804: lw x6,0(x0) with ReadData = DEADBEEF
    drive(32'h0000_2303, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 3'b000, 32'hDEAD_BEEF);
    push_chk(S_PC, 0, 32'h804, "jal_target");
    push_chk(S_RF, 1, 32'h8, "jal_link");
    push_chk(S_ALU, 0, 32'h0, "lw_addr");
    tick();
    // PC 0x808: addi x7,x0,-1
    drive(32'hFFF0_0393, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_PC, 0, 32'h808, "pc_808");
    push_chk(S_RF, 6, 32'hDEAD_BEEF, "lw_data");
    push_chk(S_ALU, 0, 32'hFFFF_FFFF, "imm_fff");
    tick();
    // PC 0x80C: addi x8,x0,1
    drive(32'h0010_0413, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_RF, 7, 32'hFFFF_FFFF, "x7_neg1");
    push_chk(S_ALU, 0, 32'h1, "addi_one");
    tick();
    // PC 0x810: slt x9,x7,x8  (-1 < 1)
    drive(32'h0083_A4B3, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 3'b101, 32'h0);
    push_chk(S_RF, 8, 32'h1, "x8_one");
    push_chk(S_ALU, 0, 32'h1, "slt_signed");
    push_chk(S_WD, 0, 32'h1, "slt_wd_x8");
    tick();
    // PC 0x814: sw x7,12(x5)
    drive(32'h0072_A623, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_RF, 9, 32'h1, "slt_wb");
    push_chk(S_ALU, 0, 32'h12, "sw_addr");
    push_chk(S_WD, 0, 32'hFFFF_FFFF, "sw_data");
    tick();
    // PC 0x818..0x82C: x7 op x8, no write-back
    for (int k = 0; k < 6; k++) begin
      drive(32'h0083_8033, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, ops[k], 32'h0);
      push_chk(S_ALU, 0, opr[k], opn[k]);
      tick();
    end
    // PC 0x830: x10 <= ImmExt (-2048) via ResultSrc=11
    drive(32'h8000_0513, 1'b1, 2'b00, 1'b1, 2'b11, 1'b0, 3'b000, 32'h0);
    push_chk(S_PC, 0, 32'h830, "pc_830");
    push_chk(S_ALU, 0, 32'hFFFF_F800, "imm_neg2048");
    push_chk(S_ZERO, 0, 32'h0, "nonzero");
    tick();
    // PC 0x834: nop
    drive(32'h0000_0013, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_PC, 0, 32'h834, "pc_834");
    push_chk(S_RF, 10, 32'hFFFF_F800, "res_imm_wb");
    tick();

    // Reset mid-operation, between edges
    #1 rst_n = 1'b0;
    #1;
    push_chk(S_PC, 0, 32'h0, "midreset_pc");
    push_chk(S_RFALL, 0, 32'h0, "midreset_rf");
    push_chk(S_WD, 0, 32'h0, "midreset_wd");
    -> chk_ev;
    #1 rst_n = 1'b1;
    drive(32'h0030_0293, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_ALU, 0, 32'd3, "post_reset_alu");
    push_chk(S_PC, 0, 32'h0, "post_reset_pc");
    tick();
    drive(32'h0000_0013, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0);
    push_chk(S_PC, 0, 32'h4, "post_reset_pc4");
    push_chk(S_RF, 5, 32'd3, "post_reset_x5");
    tick();
    tick();

    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
